rr_stream_arbiter: RTL
======================

# rr_stream_arbiter

Round-robin arbiter sharing one valid/ready output stream among `NumInputs` valid/ready requesters. It sits in front of a single downstream consumer, such as a merge or serializer stage, and sequences which source gets the bus on each beat. The output is registered, with an optional per-source burst lock. It sustains one beat per cycle with 1-cycle latency.

## Interface

Parameters:
- `NumInputs`, 4: number of requester streams, ≥2
- `DataWidth`, 8: payload width per stream
- `MaxBurst`, 1: maximum consecutive beats granted to one source before rotation is forced, ≥1
- `IdWidth`, `$clog2(NumInputs)`: width of the source index, derived

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  [NumInputs]  requester valid
- `s_ready`  out  [NumInputs]  requester ready, one-hot or zero
- `s_data`  in  [NumInputs][DataWidth]  requester payload
- `m_valid`  out  1  output valid, registered
- `m_ready`  in  1  downstream ready
- `m_data`  out  DataWidth  granted payload, registered
- `m_id`  out  IdWidth  index of the source that produced `m_data`, registered

## Operation

- Single output register holds `m_valid`, `m_data` and `m_id`.
- `load = !m_valid || m_ready`. A slot is free or draining this cycle.
- Round-robin pointer `last` records the index granted most recently.
- Burst counter `burst_cnt`, width `$clog2(MaxBurst+1)`, tracks consecutive beats from `last`.

Grant selection (combinational):
- Hold: if `s_valid[last]` and `burst_cnt < MaxBurst-1`, then `g = last`.
- Otherwise, `g` is the first index with `s_valid` set, searching `last+1`, `last+2`, … with wrap mod `NumInputs`, ending at `last` itself.
- No valid requester means no grant.

When `load` and a grant exists:
- `s_ready[g] = 1`; every other `s_ready` is 0.
- Register `m_data <= s_data[g]`, `m_id <= g`, `m_valid <= 1`.
- Update `last <= g`.
- Update `burst_cnt <= (g == last) ? burst_cnt+1 : 0`.

When `load` and no grant:
- `m_valid <= 0`.
- `m_data`, `m_id`, `last` and `burst_cnt` hold.

When `!load`:
- All `s_ready` are 0; all state holds.

Boundary conditions:
- `MaxBurst=1` gives pure round-robin. The hold rule never fires.
- A source that drops `s_valid` mid-burst loses the lock immediately.
- A single active requester is re-granted every cycle regardless of `MaxBurst`. The search wraps back to `last`, and `burst_cnt` saturates at `MaxBurst-1`.

## Timing

- Reset values: `m_valid=0`, `m_data=0`, `m_id=0`, `last=NumInputs-1` (index 0 has first priority), `burst_cnt=0`.
- While `rst` is high, all `s_ready` are 0.
- Latency: a beat accepted on cycle N appears on `m_*` at cycle N+1.
- Throughput: 1 beat/cycle under continuous `m_ready=1`.
- `s_ready` depends combinationally on `m_ready`, `m_valid`, `s_valid` and state. There is no skid buffer.
- Backpressure: while `m_valid && !m_ready`, the outputs `m_data` and `m_id` are stable and all `s_ready` are 0.
- Reset mid-operation: a pending output beat is dropped (`m_valid=0` the cycle after `rst`), and the pointer and counter reinitialise.

## Structure

- Package `arb_pkg` holds:
  - the `id_t`/width helper function for `IdWidth`;
  - the reset constant for the pointer (`NumInputs-1`).
- Sub-module `rr_priority_pick` is combinational. It takes a `NumInputs`-bit request vector and a start index, and returns `found` and the `index` of the first set bit at or after the start, with wrap.
- The top level holds the output register, the pointer, the burst counter and the hold logic.

## Test plan

- Reset: `rst=1` for 2 cycles with all `s_valid=1` -> `m_valid=0` and `s_ready=0000` throughout. The first beat after release has `m_id=0`.
- Single source: only `s_valid[2]=1` with `s_data[2]=8'h5A`, `m_ready=1` -> `s_ready=0100` in that cycle. Next cycle `m_valid=1`, `m_data=8'h5A`, `m_id=2`.
- Fairness with `MaxBurst=1`: all four inputs valid continuously, `m_ready=1` -> `m_id` sequence 0,1,2,3,0,1, with no idle cycles.
- Backpressure: hold `m_ready=0` for 3 cycles while `m_valid=1`, `m_id=1` -> `m_data`/`m_id` stable and `s_ready=0000`. After `m_ready=1`, the next `m_id` is 2.
- Burst lock with `MaxBurst=2`: inputs 0 and 1 valid continuously -> `m_id` sequence 0,0,1,1,0,0. Dropping `s_valid[1]` after its first beat makes the next `m_id` 0.
- Reset mid-operation: assert `rst` while `m_valid=1`, `m_ready=0`, `last=2` -> next cycle `m_valid=0`. After release with inputs 1 and 3 valid, the first grant is `m_id=1`.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared sizing helpers for the round-robin stream arbiter.
package arb_pkg;

  // Width of a source index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointer reset value: the last index, so that index 0 has first priority.
  function automatic int unsigned last_reset(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational wrap-around priority search: the first set request bit at or after start.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int unsigned NumInputs = 4,
  localparam int unsigned IdWidth   = id_width(NumInputs)
) (
  input  logic [NumInputs-1:0] req,
  input  logic [IdWidth-1:0]   start,
  output logic                 found,
  output logic [IdWidth-1:0]   index
);

  // Walk the requests from start with wrap; the first hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      if (!found && req[IdWidth'((32'(start) + i) % NumInputs)]) begin
        found = 1'b1;
        index = IdWidth'((32'(start) + i) % NumInputs);
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter merging NumInputs valid/ready streams into one registered
// output stream, with an optional per-source burst lock of up to MaxBurst beats.
module rr_stream_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned NumInputs = 4,
  parameter  int unsigned DataWidth = 8,
  parameter  int unsigned MaxBurst  = 1,
  localparam int unsigned IdWidth   = id_width(NumInputs)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NumInputs-1:0]                s_valid,
  output logic [NumInputs-1:0]                s_ready,
  input  logic [NumInputs-1:0][DataWidth-1:0] s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DataWidth-1:0]                m_data,
  output logic [IdWidth-1:0]                  m_id
);

  localparam int unsigned          CntWidth = $clog2(MaxBurst + 1);
  localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(MaxBurst - 1);
  localparam logic [IdWidth-1:0]   LastIdx  = IdWidth'(NumInputs - 1);
  localparam logic [IdWidth-1:0]   LastRst  = IdWidth'(last_reset(NumInputs));

  logic [IdWidth-1:0]  last;
  logic [CntWidth-1:0] burst_cnt;

  logic                load_c;
  logic [IdWidth-1:0]  start_c;
  logic                hold_c;
  logic                pick_found_c;
  logic [IdWidth-1:0]  pick_idx_c;
  logic                grant_found_c;
  logic [IdWidth-1:0]  grant_c;
  logic [CntWidth-1:0] next_cnt_c;

  // Search begins just after the most recent grant and wraps back to it.
  always_comb begin
    load_c  = !m_valid || m_ready;
    start_c = (last == LastIdx) ? '0 : last + IdWidth'(1);
  end

  rr_priority_pick #(
    .NumInputs (NumInputs)
  ) u_pick (
    .req   (s_valid),
    .start (start_c),
    .found (pick_found_c),
    .index (pick_idx_c)
  );

  // Burst lock keeps the current source while it stays valid and has beats left.
  always_comb begin
    hold_c        = s_valid[last] && (burst_cnt < CntMax);
    grant_found_c = hold_c || pick_found_c;
    grant_c       = hold_c ? last : pick_idx_c;
    next_cnt_c    = (burst_cnt >= CntMax) ? CntMax : burst_cnt + CntWidth'(1);
  end

  // One-hot ready toward the granted source when the output slot can take a beat.
  always_comb begin
    s_ready = '0;
    if (!rst && load_c && grant_found_c) begin
      s_ready[grant_c] = 1'b1;
    end
  end

  // Output register, round-robin pointer and burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_id      <= '0;
      last      <= LastRst;
      burst_cnt <= '0;
    end else if (load_c) begin
      if (grant_found_c) begin
        m_valid   <= 1'b1;
        m_data    <= s_data[grant_c];
        m_id      <= grant_c;
        last      <= grant_c;
        burst_cnt <= (grant_c == last) ? next_cnt_c : '0;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
